// File: rtl/mcu_lcd_stream.sv
// 8080-style MCU LCD pixel streamer: per frame sends the window/RAM-write command set, then bursts RGB565 pixels from a FIFO.
// Optional build macro MLCD_TE_SYNC_EN gates each frame's command set on a rising lcd_te edge.
module mcu_lcd_stream #(
   parameter int H_PIXEL = 800,
   parameter int V_PIXEL = 480,
   parameter int BUS_W   = 16,
   parameter int WR_LOW  = 1,
   parameter int WR_HIGH = 1,
   parameter int BURST   = 16,
   parameter int LVL_W   = 9
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             init_done,
   input  logic [LVL_W-1:0] pix_level,
   output logic             pix_rdreq,
   input  logic [15:0]      pix_data,
   input  logic             lcd_te,
   output logic             mlcd_cs_n,
   output logic             mlcd_wr_n,
   output logic             mlcd_rd_n,
   output logic             mlcd_rs,
   output logic [BUS_W-1:0] mlcd_dout,
   output logic             mlcd_dout_en,
   output logic             frame_done,
   output logic             busy
);

   localparam int TOTAL = H_PIXEL * V_PIXEL;
   localparam int CMAX  = (TOTAL > BURST) ? TOTAL : BURST;
   localparam int CW    = $clog2(CMAX + 1);
   localparam int XW    = $clog2(H_PIXEL + 1);
   localparam int YW    = $clog2(V_PIXEL + 1);
   localparam int BCW   = $clog2(WR_LOW + WR_HIGH + 1);

   localparam logic [BCW-1:0] BEAT_LAST = BCW'(WR_LOW + WR_HIGH - 1);
   localparam logic [BCW-1:0] LOW_CYC   = BCW'(WR_LOW);
   localparam logic [CW-1:0]  TOTAL_C   = CW'(TOTAL);
   localparam logic [CW-1:0]  BURST_C   = CW'(BURST);
   localparam logic [XW-1:0]  X_LAST    = XW'(H_PIXEL - 1);
   localparam logic [YW-1:0]  Y_LAST    = YW'(V_PIXEL - 1);
   localparam logic [15:0]    H_M1      = 16'(H_PIXEL - 1);
   localparam logic [15:0]    V_M1      = 16'(V_PIXEL - 1);

   typedef enum logic [2:0] {
      IDLE, TE_WAIT, CMD, LEVEL_WAIT, FETCH, PIXEL
   } state_t;

   state_t           state_q, state_d;
   logic [BCW-1:0]   bcnt_q, bcnt_d;
   logic [3:0]       widx_q, widx_d;
   logic [XW-1:0]    x_q, x_d;
   logic [YW-1:0]    y_q, y_d;
   logic [CW-1:0]    left_q, left_d;
   logic [CW-1:0]    burst_q, burst_d;
   logic [CW-1:0]    need;
   logic [15:0]      pix_q, pix_d;
   logic             lo_q, lo_d;
   logic             ph_q, ph_d;
   logic             beat_end, frame_end, te_rise;
   logic             cs_n_d, wr_n_d, rs_d;
   logic [BUS_W-1:0] dout_d, pix_bus;

`ifdef MLCD_TE_SYNC_EN
   localparam state_t FRAME_START = TE_WAIT;
   logic te_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) te_q <= 1'b0;
      else        te_q <= lcd_te;
   end
   assign te_rise = lcd_te & ~te_q;
`else
   localparam state_t FRAME_START = CMD;
   logic unused_te;

   assign unused_te = lcd_te;
   assign te_rise   = 1'b0;
`endif

   // Command-phase byte sequence: CASET / RASET with full-panel window, then RAMWR.
   function automatic logic [7:0] cmd_byte(input logic [3:0] idx);
      case (idx)
         4'd0:    cmd_byte = 8'h2A;
         4'd3:    cmd_byte = H_M1[15:8];
         4'd4:    cmd_byte = H_M1[7:0];
         4'd5:    cmd_byte = 8'h2B;
         4'd8:    cmd_byte = V_M1[15:8];
         4'd9:    cmd_byte = V_M1[7:0];
         4'd10:   cmd_byte = 8'h2C;
         default: cmd_byte = 8'h00;
      endcase
   endfunction

   assign beat_end = (bcnt_q == BEAT_LAST);
   assign need     = (left_q < BURST_C) ? left_q : BURST_C;

   // NOTE: every variable gets a default before the case so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      bcnt_d    = bcnt_q;
      widx_d    = widx_q;
      x_d       = x_q;
      y_d       = y_q;
      left_d    = left_q;
      burst_d   = burst_q;
      pix_d     = pix_q;
      lo_d      = lo_q;
      ph_d      = ph_q;
      frame_end = 1'b0;
      case (state_q)
         IDLE:    if (init_done) state_d = FRAME_START;
         TE_WAIT: if (te_rise) state_d = CMD;
         CMD: begin
            if (!beat_end) begin
               bcnt_d = bcnt_q + 1'b1;
            end else begin
               bcnt_d = '0;
               if (widx_q == 4'd10) begin
                  widx_d  = '0;
                  left_d  = TOTAL_C;
                  state_d = LEVEL_WAIT;
               end else begin
                  widx_d = widx_q + 1'b1;
               end
            end
         end
         LEVEL_WAIT: begin
            if (32'(pix_level) >= 32'(need)) begin
               burst_d = need;
               ph_d    = 1'b0;
               state_d = FETCH;
            end
         end
         FETCH: begin
            // Phase 0 strobes the FIFO; phase 1 captures its registered output.
            if (!ph_q) begin
               ph_d = 1'b1;
            end else begin
               ph_d    = 1'b0;
               pix_d   = pix_data;
               lo_d    = 1'b0;
               bcnt_d  = '0;
               state_d = PIXEL;
            end
         end
         PIXEL: begin
            if (!beat_end) begin
               bcnt_d = bcnt_q + 1'b1;
            end else begin
               bcnt_d = '0;
               if (BUS_W == 8 && !lo_q) begin
                  lo_d = 1'b1;
               end else begin
                  lo_d    = 1'b0;
                  burst_d = burst_q - 1'b1;
                  left_d  = left_q - 1'b1;
                  if (x_q == X_LAST) begin
                     x_d = '0;
                     y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
                  end else begin
                     x_d = x_q + 1'b1;
                  end
                  if (burst_q != CW'(1)) begin
                     state_d = FETCH;
                  end else if (left_q != CW'(1)) begin
                     state_d = LEVEL_WAIT;
                  end else begin
                     frame_end = 1'b1;
                     x_d       = '0;
                     y_d       = '0;
                     state_d   = FRAME_START;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (!init_done) begin
         state_d   = IDLE;
         bcnt_d    = '0;
         widx_d    = '0;
         x_d       = '0;
         y_d       = '0;
         left_d    = '0;
         burst_d   = '0;
         pix_d     = '0;
         lo_d      = 1'b0;
         ph_d      = 1'b0;
         frame_end = 1'b0;
      end
   end

   always_comb begin
      if (BUS_W == 16) pix_bus = BUS_W'(pix_q);
      else             pix_bus = lo_q ? BUS_W'(pix_q[7:0]) : BUS_W'(pix_q[15:8]);
   end

   // Bus pins are registered from the current state, so they trail the FSM by one cycle.
   always_comb begin
      cs_n_d = 1'b1;
      wr_n_d = 1'b1;
      rs_d   = 1'b1;
      dout_d = mlcd_dout;
      case (state_q)
         CMD: begin
            cs_n_d = 1'b0;
            wr_n_d = (bcnt_q >= LOW_CYC);
            rs_d   = !(widx_q == 4'd0 || widx_q == 4'd5 || widx_q == 4'd10);
            dout_d = BUS_W'(cmd_byte(widx_q));
         end
         PIXEL: begin
            cs_n_d = 1'b0;
            wr_n_d = (bcnt_q >= LOW_CYC);
            dout_d = pix_bus;
         end
         LEVEL_WAIT, FETCH: cs_n_d = 1'b0;
         default:           dout_d = '0;
      endcase
      if (!init_done) begin
         cs_n_d = 1'b1;
         wr_n_d = 1'b1;
         rs_d   = 1'b1;
         dout_d = '0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         bcnt_q     <= '0;
         widx_q     <= '0;
         x_q        <= '0;
         y_q        <= '0;
         left_q     <= '0;
         burst_q    <= '0;
         pix_q      <= '0;
         lo_q       <= 1'b0;
         ph_q       <= 1'b0;
         mlcd_cs_n  <= 1'b1;
         mlcd_wr_n  <= 1'b1;
         mlcd_rs    <= 1'b1;
         mlcd_dout  <= '0;
         pix_rdreq  <= 1'b0;
         frame_done <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state_q    <= state_d;
         bcnt_q     <= bcnt_d;
         widx_q     <= widx_d;
         x_q        <= x_d;
         y_q        <= y_d;
         left_q     <= left_d;
         burst_q    <= burst_d;
         pix_q      <= pix_d;
         lo_q       <= lo_d;
         ph_q       <= ph_d;
         mlcd_cs_n  <= cs_n_d;
         mlcd_wr_n  <= wr_n_d;
         mlcd_rs    <= rs_d;
         mlcd_dout  <= dout_d;
         pix_rdreq  <= (state_d == FETCH) && !ph_d;
         frame_done <= frame_end;
         busy       <= (state_d != IDLE);
      end
   end

   assign mlcd_rd_n    = 1'b1;
   assign mlcd_dout_en = ~mlcd_cs_n;

endmodule

// File: tb/tb_mcu_lcd_stream.sv
// Directed bench for mcu_lcd_stream: four parameterisations exercising framing, 8-bit split, beat timing,
// truncated final burst, and init_done abort.
module tb_mcu_lcd_stream;

   logic clk = 1'b0;
   logic rst_n;
   logic te = 1'b0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- instance A: 4x2, 16-bit, burst 4 ----------------
   logic        a_init, a_rdreq, a_cs_n, a_wr_n, a_rd_n, a_rs, a_den, a_fd, a_busy;
   logic [15:0] a_data, a_dout;
   int          a_rd_idx = 0, a_rd_cnt = 0, a_fd_cnt = 0;
   logic        a_wr_prev = 1'b1;
   logic [15:0] a_beats[$];
   logic        a_rss[$];

   mcu_lcd_stream #(.H_PIXEL(4), .V_PIXEL(2), .BUS_W(16), .WR_LOW(1), .WR_HIGH(1), .BURST(4), .LVL_W(9)) u_a (
      .clk(clk), .rst_n(rst_n), .init_done(a_init), .pix_level(9'd8), .pix_rdreq(a_rdreq),
      .pix_data(a_data), .lcd_te(te), .mlcd_cs_n(a_cs_n), .mlcd_wr_n(a_wr_n), .mlcd_rd_n(a_rd_n),
      .mlcd_rs(a_rs), .mlcd_dout(a_dout), .mlcd_dout_en(a_den), .frame_done(a_fd), .busy(a_busy));

   always @(posedge clk) if (a_rdreq) begin #1 a_data = 16'hA000 + 16'(a_rd_idx); a_rd_idx++; end

   always @(negedge clk) begin
      if (a_wr_n && !a_wr_prev && !a_cs_n) begin a_beats.push_back(a_dout); a_rss.push_back(a_rs); end
      a_wr_prev = a_wr_n;
      if (a_rdreq) a_rd_cnt++;
      if (a_fd) a_fd_cnt++;
   end

   // ---------------- instance B: 2x1, 8-bit bus ----------------
   logic        b_init, b_rdreq, b_cs_n, b_wr_n, b_rd_n, b_rs, b_den, b_fd, b_busy;
   logic [15:0] b_data;
   logic [7:0]  b_dout;
   int          b_rd_idx = 0, b_fd_cnt = 0;
   logic        b_wr_prev = 1'b1;
   logic [15:0] b_beats[$];
   logic        b_rss[$];

   mcu_lcd_stream #(.H_PIXEL(2), .V_PIXEL(1), .BUS_W(8), .WR_LOW(1), .WR_HIGH(1), .BURST(2), .LVL_W(9)) u_b (
      .clk(clk), .rst_n(rst_n), .init_done(b_init), .pix_level(9'd8), .pix_rdreq(b_rdreq),
      .pix_data(b_data), .lcd_te(te), .mlcd_cs_n(b_cs_n), .mlcd_wr_n(b_wr_n), .mlcd_rd_n(b_rd_n),
      .mlcd_rs(b_rs), .mlcd_dout(b_dout), .mlcd_dout_en(b_den), .frame_done(b_fd), .busy(b_busy));

   always @(posedge clk) if (b_rdreq) begin #1 b_data = (b_rd_idx == 0) ? 16'hF81F : 16'h1234; b_rd_idx++; end

   always @(negedge clk) begin
      if (b_wr_n && !b_wr_prev && !b_cs_n) begin b_beats.push_back(16'(b_dout)); b_rss.push_back(b_rs); end
      b_wr_prev = b_wr_n;
      if (b_fd) b_fd_cnt++;
   end

   // ---------------- instance C: 2x1, WR_LOW=2 / WR_HIGH=3 ----------------
   logic        c_init, c_rdreq, c_cs_n, c_wr_n, c_rd_n, c_rs, c_den, c_fd, c_busy;
   logic [15:0] c_data, c_dout;
   int          c_rd_idx = 0, c_fd_cnt = 0;
   logic        c_wr_prev = 1'b1;
   logic [15:0] c_beats[$];

   mcu_lcd_stream #(.H_PIXEL(2), .V_PIXEL(1), .BUS_W(16), .WR_LOW(2), .WR_HIGH(3), .BURST(2), .LVL_W(9)) u_c (
      .clk(clk), .rst_n(rst_n), .init_done(c_init), .pix_level(9'd8), .pix_rdreq(c_rdreq),
      .pix_data(c_data), .lcd_te(te), .mlcd_cs_n(c_cs_n), .mlcd_wr_n(c_wr_n), .mlcd_rd_n(c_rd_n),
      .mlcd_rs(c_rs), .mlcd_dout(c_dout), .mlcd_dout_en(c_den), .frame_done(c_fd), .busy(c_busy));

   always @(posedge clk) if (c_rdreq) begin #1 c_data = 16'h0C00 + 16'(c_rd_idx); c_rd_idx++; end

   always @(negedge clk) begin
      if (c_wr_n && !c_wr_prev && !c_cs_n) c_beats.push_back(c_dout);
      c_wr_prev = c_wr_n;
      if (c_fd) c_fd_cnt++;
   end

   // ---------------- instance D: 5x1, burst 4, level-controlled ----------------
   logic        d_init, d_rdreq, d_cs_n, d_wr_n, d_rd_n, d_rs, d_den, d_fd, d_busy;
   logic [15:0] d_data, d_dout;
   logic [8:0]  d_level;
   int          d_rd_idx = 0, d_rd_cnt = 0, d_fd_cnt = 0;
   logic        d_wr_prev = 1'b1;
   logic [15:0] d_beats[$];

   mcu_lcd_stream #(.H_PIXEL(5), .V_PIXEL(1), .BUS_W(16), .WR_LOW(1), .WR_HIGH(1), .BURST(4), .LVL_W(9)) u_d (
      .clk(clk), .rst_n(rst_n), .init_done(d_init), .pix_level(d_level), .pix_rdreq(d_rdreq),
      .pix_data(d_data), .lcd_te(te), .mlcd_cs_n(d_cs_n), .mlcd_wr_n(d_wr_n), .mlcd_rd_n(d_rd_n),
      .mlcd_rs(d_rs), .mlcd_dout(d_dout), .mlcd_dout_en(d_den), .frame_done(d_fd), .busy(d_busy));

   always @(posedge clk) if (d_rdreq) begin #1 d_data = 16'h0D00 + 16'(d_rd_idx); d_rd_idx++; end

   always @(negedge clk) begin
      if (d_wr_n && !d_wr_prev && !d_cs_n) d_beats.push_back(d_dout);
      d_wr_prev = d_wr_n;
      if (d_rdreq) d_rd_cnt++;
      if (d_fd) d_fd_cnt++;
   end

   // Expected frame for instance A: 11 command words then 8 pixels in FIFO order.
   logic [15:0] a_exp[19] = '{16'h2A, 16'h00, 16'h00, 16'h00, 16'h03, 16'h2B, 16'h00, 16'h00, 16'h00, 16'h01, 16'h2C,
                              16'hA000, 16'hA001, 16'hA002, 16'hA003, 16'hA004, 16'hA005, 16'hA006, 16'hA007};
   logic        a_rs_exp[19] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                                 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

   initial begin
      int         n;
      logic [5:0] wr_pat;
      a_init = 1'b0; b_init = 1'b0; c_init = 1'b0; d_init = 1'b0;
      a_data = '0; b_data = '0; c_data = '0; d_data = '0; d_level = 9'd1;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);

      // reset values
      check("rst_cs_n", a_cs_n, 1);
      check("rst_wr_n", a_wr_n, 1);
      check("rst_rd_n", a_rd_n, 1);
      check("rst_rs", a_rs, 1);
      check("rst_dout", a_dout, 0);
      check("rst_dout_en", a_den, 0);
      check("rst_rdreq", a_rdreq, 0);
      check("rst_frame_done", a_fd, 0);
      check("rst_busy", a_busy, 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_busy", a_busy, 0);
      check("idle_cs_n", a_cs_n, 1);

      // A: one full frame
      a_init = 1'b1;
      for (int i = 0; i < 400 && a_fd_cnt == 0; i++) @(negedge clk);
      a_init = 1'b0;
      repeat (3) @(negedge clk);
      check("a_frame_done_pulses", a_fd_cnt, 1);
      check("a_rdreq_pulses", a_rd_cnt, 8);
      check("a_beat_count", a_beats.size(), 19);
      for (int i = 0; i < 19 && i < a_beats.size(); i++) begin
         check($sformatf("a_beat%0d_data", i), a_beats[i], a_exp[i]);
         check($sformatf("a_beat%0d_rs", i), a_rss[i], a_rs_exp[i]);
      end
      check("a_idle_cs_n", a_cs_n, 1);

      // A: abort in the middle of a pixel beat, then restart
      a_beats.delete(); a_rss.delete();
      a_init = 1'b1;
      for (int i = 0; i < 400 && a_beats.size() < 13; i++) @(negedge clk);
      for (int i = 0; i < 20 && a_wr_n !== 1'b0; i++) @(negedge clk);
      check("abort_in_pixel_beat", a_wr_n, 0);
      n = a_beats.size();
      a_init = 1'b0;
      @(posedge clk); #1;
      check("abort_cs_n", a_cs_n, 1);
      check("abort_wr_n", a_wr_n, 1);
      check("abort_busy", a_busy, 0);
      check("abort_dout", a_dout, 0);
      check("abort_dout_en", a_den, 0);
      @(negedge clk);
      check("abort_no_latch", a_beats.size(), n);
      a_beats.delete(); a_rss.delete();
      a_init = 1'b1;
      for (int i = 0; i < 50 && a_beats.size() == 0; i++) @(negedge clk);
      check("restart_beat_seen", a_beats.size(), 1);
      if (a_beats.size() > 0) begin
         check("restart_first_word", a_beats[0], 16'h2A);
         check("restart_first_rs", a_rss[0], 0);
      end
      a_init = 1'b0;

      // B: 8-bit bus splits each pixel high byte first
      b_init = 1'b1;
      for (int i = 0; i < 400 && b_fd_cnt == 0; i++) @(negedge clk);
      b_init = 1'b0;
      repeat (3) @(negedge clk);
      check("b_frame_done_pulses", b_fd_cnt, 1);
      check("b_beat_count", b_beats.size(), 15);
      if (b_beats.size() >= 15) begin
         check("b_h_low_byte", b_beats[4], 16'h01);
         check("b_pix0_hi", b_beats[11], 16'hF8);
         check("b_pix0_hi_rs", b_rss[11], 1);
         check("b_pix0_lo", b_beats[12], 16'h1F);
         check("b_pix0_lo_rs", b_rss[12], 1);
         check("b_pix1_hi", b_beats[13], 16'h12);
         check("b_pix1_lo", b_beats[14], 16'h34);
      end

      // C: stretched beat timing
      c_init = 1'b1;
      for (int i = 0; i < 20 && c_wr_n !== 1'b0; i++) @(negedge clk);
      wr_pat = '0;
      for (int k = 0; k < 6; k++) begin
         wr_pat[k] = c_wr_n;
         if (k < 5) check($sformatf("c_dout_hold%0d", k), c_dout, 16'h2A);
         else       check("c_second_word", c_dout, 16'h00);
         if (k < 5) @(negedge clk);
      end
      check("c_wr_pattern", 32'(wr_pat), 32'(6'b011100));
      for (int i = 0; i < 400 && c_fd_cnt == 0; i++) @(negedge clk);
      c_init = 1'b0;
      repeat (3) @(negedge clk);
      check("c_beat_count", c_beats.size(), 13);
      if (c_beats.size() >= 13) begin
         check("c_pix0", c_beats[11], 16'h0C00);
         check("c_pix1", c_beats[12], 16'h0C01);
      end

      // D: level gating and truncated final burst
      d_level = 9'd1;
      d_init = 1'b1;
      repeat (40) @(negedge clk);
      check("d_cmd_beats", d_beats.size(), 11);
      check("d_no_fetch_lvl1", d_rd_cnt, 0);
      d_level = 9'd3;
      repeat (10) @(negedge clk);
      check("d_no_fetch_lvl3", d_rd_cnt, 0);
      d_level = 9'd4;
      for (int i = 0; i < 100 && d_rd_cnt < 4; i++) @(negedge clk);
      d_level = 9'd0;
      repeat (20) @(negedge clk);
      check("d_first_burst_reads", d_rd_cnt, 4);
      check("d_first_burst_beats", d_beats.size(), 15);
      d_level = 9'd1;
      for (int i = 0; i < 100 && d_fd_cnt == 0; i++) @(negedge clk);
      d_init = 1'b0;
      repeat (3) @(negedge clk);
      check("d_total_reads", d_rd_cnt, 5);
      check("d_frame_done_pulses", d_fd_cnt, 1);
      check("d_total_beats", d_beats.size(), 16);
      if (d_beats.size() >= 16) check("d_last_pixel", d_beats[15], 16'h0D04);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
